// File: rtl/ram_bist_pkg.sv
// Shared state encoding and run-length constant for the RAM BIST sequencer.
package ram_bist_pkg;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_W_BG   = 3'd1;
   localparam logic [2:0] S_RW_INV = 3'd2;
   localparam logic [2:0] S_RD_INV = 3'd3;
   localparam logic [2:0] S_DRAIN  = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   typedef enum logic [2:0] {
      IDLE   = S_IDLE,
      W_BG   = S_W_BG,
      RW_INV = S_RW_INV,
      RD_INV = S_RD_INV,
      DRAIN  = S_DRAIN,
      DONE   = S_DONE
   } state_t;

   // Busy cycles of one complete march: DEPTH + 2*DEPTH + DEPTH + drain.
   function automatic int bist_cycles(input int depth);
      return 4 * depth + 1;
   endfunction

   localparam int BIST_CYCLES_DFLT = bist_cycles(64);

endpackage

// File: rtl/ram_bist_checker.sv
// Read-data checker: registers each issued read, compares ram_dout one
// cycle later, counts mismatches and captures the first failing word.
module ram_bist_checker #(
   parameter int WIDTH    = 8,
   parameter int ADDR_BUS = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_clr,
   input  logic                  i_issue,
   input  logic [WIDTH-1:0]      i_exp_data,
   input  logic [ADDR_BUS-1:0]   i_exp_addr,
   input  logic [WIDTH-1:0]      i_ram_dout,
   output logic                  o_mismatch,
   output logic [ADDR_BUS+1:0]   o_err_count,
   output logic [ADDR_BUS-1:0]   o_fail_addr,
   output logic [WIDTH-1:0]      o_fail_data
);

   logic                r_pending;
   logic [WIDTH-1:0]    r_exp_data;
   logic [ADDR_BUS-1:0] r_exp_addr;
   logic [ADDR_BUS+1:0] r_err;
   logic [ADDR_BUS-1:0] r_fail_addr;
   logic [WIDTH-1:0]    r_fail_data;

   assign o_mismatch  = r_pending && (i_ram_dout != r_exp_data);
   assign o_err_count = r_err;
   assign o_fail_addr = r_fail_addr;
   assign o_fail_data = r_fail_data;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_pending   <= 1'b0;
         r_exp_data  <= '0;
         r_exp_addr  <= '0;
         r_err       <= '0;
         r_fail_addr <= '0;
         r_fail_data <= '0;
      end else begin
         r_pending <= i_issue;
         if (i_issue) begin
            r_exp_data <= i_exp_data;
            r_exp_addr <= i_exp_addr;
         end
         if (o_mismatch) begin
            r_err <= r_err + 1'b1;
            if (r_err == '0) begin
               r_fail_addr <= r_exp_addr;
               r_fail_data <= i_ram_dout;
            end
         end
      end
   end

endmodule

// File: rtl/ram_bist_ctrl.sv
// Three-phase march BIST sequencer for single_port_RAM.
// Optional BIST_STOP_ON_FAIL_EN: abort to DONE on the first mismatch.
module ram_bist_ctrl
   import ram_bist_pkg::*;
#(
   parameter int                 WIDTH    = 8,
   parameter int                 DEPTH    = 64,
   parameter int                 ADDR_BUS = $clog2(DEPTH),
   parameter logic [WIDTH-1:0]   PATTERN  = 8'hA5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ADDR_BUS+1:0]   err_count,
   output logic [ADDR_BUS-1:0]   fail_addr,
   output logic [WIDTH-1:0]      fail_data,
   output logic                  ram_we,
   output logic [ADDR_BUS-1:0]   ram_addr,
   output logic [WIDTH-1:0]      ram_din,
   input  logic [WIDTH-1:0]      ram_dout
);

`ifdef BIST_STOP_ON_FAIL_EN
   localparam bit STOP_EN = 1'b1;
`else
   localparam bit STOP_EN = 1'b0;
`endif

   localparam logic [ADDR_BUS-1:0] LAST = ADDR_BUS'(DEPTH - 1);
   localparam logic [ADDR_BUS-1:0] ONE  = ADDR_BUS'(1);

   state_t              r_state, w_state_nxt;
   logic [ADDR_BUS-1:0] r_cnt, w_cnt_nxt;
   logic                r_sub, w_sub_nxt;
   logic                w_issue, w_clr, w_mismatch;
   logic [WIDTH-1:0]    w_exp;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_sub   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_sub   <= w_sub_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_sub_nxt   = r_sub;
      ram_we      = 1'b0;
      ram_addr    = '0;
      ram_din     = '0;
      w_issue     = 1'b0;
      w_exp       = PATTERN;
      w_clr       = 1'b0;
      unique case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_state_nxt = W_BG;
               w_cnt_nxt   = '0;
               w_sub_nxt   = 1'b0;
               w_clr       = 1'b1;
            end
         end
         W_BG: begin
            ram_we   = 1'b1;
            ram_addr = r_cnt;
            ram_din  = PATTERN;
            if (r_cnt == LAST) begin
               w_state_nxt = RW_INV;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + ONE;
            end
         end
         RW_INV: begin
            ram_addr = r_cnt;
            if (!r_sub) begin
               w_issue   = 1'b1;
               w_sub_nxt = 1'b1;
            end else begin
               ram_we    = 1'b1;
               ram_din   = ~PATTERN;
               w_sub_nxt = 1'b0;
               if (r_cnt == LAST) begin
                  w_state_nxt = RD_INV;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + ONE;
               end
            end
         end
         RD_INV: begin
            ram_addr = r_cnt;
            w_issue  = 1'b1;
            w_exp    = ~PATTERN;
            if (r_cnt == LAST) begin
               w_state_nxt = DRAIN;
            end else begin
               w_cnt_nxt = r_cnt + ONE;
            end
         end
         DRAIN: w_state_nxt = DONE;
         default: w_state_nxt = IDLE;
      endcase
      // Abort: the write decoded this cycle still lands, no new read starts.
      if (STOP_EN && w_mismatch) begin
         w_state_nxt = DONE;
         w_issue     = 1'b0;
      end
   end

   ram_bist_checker #(
      .WIDTH    (WIDTH),
      .ADDR_BUS (ADDR_BUS)
   ) u_checker (
      .clk         (clk),
      .rst         (rst),
      .i_clr       (w_clr),
      .i_issue     (w_issue),
      .i_exp_data  (w_exp),
      .i_exp_addr  (ram_addr),
      .i_ram_dout  (ram_dout),
      .o_mismatch  (w_mismatch),
      .o_err_count (err_count),
      .o_fail_addr (fail_addr),
      .o_fail_data (fail_data)
   );

   assign busy = (r_state == W_BG) || (r_state == RW_INV) ||
                 (r_state == RD_INV) || (r_state == DRAIN);
   assign done = (r_state == DONE);
   assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Randomized fault-injection bench for ram_bist_ctrl with an in-bench RAM
// and an abstract march model of the expected outcome.
module tb_ram_bist_ctrl;

`ifdef BIST_STOP_ON_FAIL_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   localparam int D = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       busy, done, pass, ram_we;
   logic [7:0] err_count;
   logic [5:0] fail_addr, ram_addr;
   logic [7:0] fail_data, ram_din, ram_dout;

   int n_chk = 0;
   int n_pass = 0;

   bit f_en = 1'b0;
   int f_addr = 0;
   int f_bit = 0;
   bit f_val = 1'b0;

   logic [7:0] mem [D];

   always #5 clk = ~clk;

   ram_bist_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .fail_addr (fail_addr),
      .fail_data (fail_data),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout)
   );

   function automatic logic [7:0] flt(input int a, input logic [7:0] d);
      logic [7:0] r;
      r = d;
      if (f_en && a == f_addr) r[f_bit] = f_val;
      return r;
   endfunction

   // Single-port RAM with optional stuck-at bit, read-before-write.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= flt(int'(ram_addr), ram_din);
      ram_dout <= flt(int'(ram_addr), mem[ram_addr]);
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic run_march(input bit en, input int fa, input int fb,
                            input bit fv, input bit poke);
      int e_err, e_cyc, cyc, bad;
      logic [7:0] e_addr, e_data, w, r;
      f_en = en; f_addr = fa; f_bit = fb; f_val = fv;
      e_err = 0; e_cyc = 4 * D + 1; e_addr = 0; e_data = 0;
      for (int p = 0; p < 2; p++) begin
         w = (p == 0) ? 8'hA5 : 8'h5A;
         for (int a = 0; a < D; a++) begin
            r = flt(a, w);
            if (r != w) begin
               if (e_err == 0) begin
                  e_addr = 8'(a);
                  e_data = r;
                  if (STOP) e_cyc = (p == 0) ? D + 2 * a + 2 : 3 * D + a + 2;
               end
               e_err++;
            end
         end
      end
      if (STOP && e_err > 1) e_err = 1;

      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("cleared_done", {31'd0, done}, 32'd0);
      check("cleared_err", {24'd0, err_count}, 32'd0);
      cyc = 0;
      while (busy && cyc < 2000) begin
         cyc++;
         start = poke && ($urandom_range(0, 15) == 0);
         @(negedge clk);
      end
      start = 1'b0;
      check("busy_cycles", cyc, e_cyc);
      check("done", {31'd0, done}, 32'd1);
      check("pass", {31'd0, pass}, (e_err == 0) ? 32'd1 : 32'd0);
      check("err_count", {24'd0, err_count}, e_err);
      check("fail_addr", {26'd0, fail_addr}, {24'd0, e_addr});
      check("fail_data", {24'd0, fail_data}, {24'd0, e_data});
      repeat (3) @(negedge clk);
      check("we_idle", {31'd0, ram_we}, 32'd0);
      check("done_held", {31'd0, done}, 32'd1);
      if (!en) begin
         bad = 0;
         for (int i = 0; i < D; i++) if (mem[i] !== 8'h5A) bad++;
         check("mem_5A", bad, 0);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_pass", {31'd0, pass}, 32'd0);
      check("rst_err", {24'd0, err_count}, 32'd0);
      check("rst_faddr", {26'd0, fail_addr}, 32'd0);
      check("rst_fdata", {24'd0, fail_data}, 32'd0);
      check("rst_we", {31'd0, ram_we}, 32'd0);
      check("rst_addr", {26'd0, ram_addr}, 32'd0);
      check("rst_din", {24'd0, ram_din}, 32'd0);
      start = 1'b1;
      @(negedge clk);
      check("rst_beats_start", {31'd0, busy}, 32'd0);
      start = 1'b0;
      rst = 1'b0;

      run_march(1'b0, 0, 0, 1'b0, 1'b0);
      run_march(1'b1, 16, 0, 1'b0, 1'b0);
      run_march(1'b1, 63, 7, 1'b1, 1'b0);
      run_march(1'b0, 0, 0, 1'b0, 1'b1);

      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (99) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_we", {31'd0, ram_we}, 32'd0);
      check("midrst_err", {24'd0, err_count}, 32'd0);
      rst = 1'b0;
      run_march(1'b0, 0, 0, 1'b0, 1'b0);

      repeat (6)
         run_march(1'b1, int'($urandom_range(0, D - 1)),
                   int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
      run_march(1'b0, 0, 0, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
